wrr_interval_ctrl: RTL and testbench

- Interval scheduler and configuration controller for the 4-channel weighted-round-robin bus arbiter.
- Holds programmable per-master weights behind a small register interface and applies them only at interval boundaries.
- Pulses req_n_valid to open each arbitration interval.
- Watches grant tenure and force-ends hung masters through force_end_vec. Integration ORs force_end_vec into the arbiter's end_access_vec.

---
 rtl/wrr_ctrl_pkg.sv | 38 +++
 rtl/wrr_interval_ctrl_if.sv | 37 +++
 rtl/wrr_interval_ctrl_watchdog.sv | 65 ++++++
 rtl/wrr_interval_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wrr_interval_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_ctrl_pkg.sv
// Shared definitions for the WRR interval controller.
// Contents: sizing constants, FSM state encoding, register map addresses,
// reset defaults of the configuration registers and a one-hot index helper.
package wrr_ctrl_pkg;

    localparam int NUM_CH = 4;
    localparam int WT_W   = 4;
    localparam int IVL_W  = 16;
    localparam int TO_W   = 8;

    // Encoding is visible to software through STATUS[4:3].
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_WT_STAGE = 3'd1;
    localparam logic [2:0] ADDR_IVL_LEN  = 3'd2;
    localparam logic [2:0] ADDR_TO_LEN   = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_GNT_SNAP = 3'd5;

    localparam logic [NUM_CH*WT_W-1:0] WT_RST  = 16'h1111;
    localparam logic [IVL_W-1:0]       IVL_RST = 16'd256;
    localparam logic [TO_W-1:0]        TO_RST  = 8'd0;

    // Index of the set bit of a one-hot grant vector (0 when none is set).
    function automatic logic [1:0] onehot_idx(input logic [NUM_CH-1:0] v);
        onehot_idx = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (v[i]) onehot_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/wrr_interval_ctrl_if.sv
// Bundle of the configuration bus and arbiter-side signals of the WRR
// interval controller.
//   master : register-bus host and arbiter/master side (drives cfg_*,
//            gnt_vec, end_access_vec; observes everything else)
//   slave  : the controller itself
interface wrr_interval_ctrl_if;

    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic [3:0]  gnt_vec;
    logic [3:0]  end_access_vec;
    logic [3:0]  req_vec_wt_0;
    logic [3:0]  req_vec_wt_1;
    logic [3:0]  req_vec_wt_2;
    logic [3:0]  req_vec_wt_3;
    logic        req_n_valid;
    logic [3:0]  force_end_vec;
    logic        interval_done;
    logic        timeout_err;

    modport master (
        output cfg_wr, cfg_addr, cfg_wdata, gnt_vec, end_access_vec,
        input  cfg_rdata, req_vec_wt_0, req_vec_wt_1, req_vec_wt_2,
               req_vec_wt_3, req_n_valid, force_end_vec, interval_done,
               timeout_err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_wdata, gnt_vec, end_access_vec,
        output cfg_rdata, req_vec_wt_0, req_vec_wt_1, req_vec_wt_2,
               req_vec_wt_3, req_n_valid, force_end_vec, interval_done,
               timeout_err
    );

endinterface

// File: rtl/wrr_interval_ctrl_watchdog.sv
// Grant tenure watchdog.
// Counts how long the current holder keeps the bus; when the tenure reaches
// to_len cycles the holder is force-ended for one cycle and an error event
// is raised.
// Ports:
//   clk, reset      clock, async active-high reset
//   active          controller is outside IDLE
//   to_len          tenure limit, 0 disables
//   gnt_vec         one-hot grant from the arbiter
//   end_access_vec  end-of-access from the masters
//   gnt_q           gnt_vec delayed by one cycle (shared with the grant counters)
//   force_end_vec   forced end for the hung holder (combinational)
//   err_set         one-cycle error event, same cycle as force_end_vec
//   err_ch          index of the last force-ended holder
module wrr_tenure_watchdog
    import wrr_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic [TO_W-1:0]   to_len,
    input  logic [NUM_CH-1:0] gnt_vec,
    input  logic [NUM_CH-1:0] end_access_vec,
    output logic [NUM_CH-1:0] gnt_q,
    output logic [NUM_CH-1:0] force_end_vec,
    output logic              err_set,
    output logic [1:0]        err_ch
);

    logic [TO_W-1:0] ten_cnt;
    logic [TO_W:0]   ten_inc;
    logic            tenure_break;
    logic            fire;

    // A tenure restarts whenever the bus goes idle, the grant moves, or the
    // holder itself ends its access.
    assign tenure_break = (gnt_vec == '0) || (gnt_vec != gnt_q) ||
                          ((end_access_vec & gnt_vec) != '0);

    // ten_cnt counts the cycles already held; this cycle makes it ten_inc.
    assign ten_inc = {1'b0, ten_cnt} + {{TO_W{1'b0}}, 1'b1};

    assign fire = active && (to_len != '0) && !tenure_break &&
                  (ten_inc == {1'b0, to_len});

    assign force_end_vec = fire ? gnt_vec : '0;
    assign err_set       = fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            ten_cnt <= '0;
            err_ch  <= 2'd0;
        end else begin
            gnt_q <= gnt_vec;
            if (!active || (to_len == '0) || tenure_break || fire)
                ten_cnt <= '0;
            else
                ten_cnt <= ten_inc[TO_W-1:0];
            if (fire)
                err_ch <= onehot_idx(gnt_vec);
        end
    end

endmodule

// File: rtl/wrr_interval_ctrl.sv
// Interval scheduler and configuration controller for the 4-channel
// weighted-round-robin arbiter. Staged weights are applied to the arbiter
// only at interval start; grants are counted per interval and snapshotted
// at interval close; hung holders are force-ended by the tenure watchdog.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    register bus and arbiter signals (slave modport)
//
// state  | meaning
// IDLE   | disabled, weights held, watchdog off
// START  | one cycle: req_n_valid, shadow <= staged weights, timer load
// RUN    | interval timer running, grants counted
// DRAIN  | waiting for the bus to be free to close the interval
module wrr_interval_ctrl
    import wrr_ctrl_pkg::*;
(
    input logic                clk,
    input logic                reset,
    wrr_interval_ctrl_if.slave bus
);

    state_t                   state, state_nxt;
    logic                     enable;
    logic [NUM_CH*WT_W-1:0]   wt_stage;
    logic [NUM_CH*WT_W-1:0]   wt_shadow;
    logic [NUM_CH*WT_W-1:0]   wt_active;
    logic [IVL_W-1:0]         ivl_len;
    logic [IVL_W-1:0]         ivl_cnt;
    logic [TO_W-1:0]          to_len;
    logic [3:0]               gnt_cnt [NUM_CH];
    logic [15:0]              snapshot;
    logic                     timeout_err;

    logic [NUM_CH-1:0]        gnt_q;
    logic                     err_set;
    logic [1:0]               err_ch;
    logic                     bus_free;
    logic                     cnt_event;
    logic                     close_ivl;
    logic                     ctrl_wr;

    assign ctrl_wr   = bus.cfg_wr && (bus.cfg_addr == ADDR_CTRL);
    assign bus_free  = (bus.gnt_vec == '0) ||
                       ((bus.end_access_vec & bus.gnt_vec) != '0);
    // A grant counts when it is new, or when the previous holder ended its
    // access (covers a back-to-back regrant of the same master).
    assign cnt_event = (bus.gnt_vec != gnt_q) ||
                       ((bus.end_access_vec & gnt_q) != '0);

    always_comb begin
        state_nxt = state;
        close_ivl = 1'b0;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_START;
            ST_START: state_nxt = ST_RUN;
            ST_RUN:   if (!enable || (ivl_cnt == IVL_W'(1))) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus_free) begin
                    close_ivl = 1'b1;
                    state_nxt = enable ? ST_START : ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // During START the arbiter already sees the staged weights.
    assign wt_active = (state == ST_START) ? wt_stage : wt_shadow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wt_shadow <= WT_RST;
            ivl_cnt   <= '0;
            snapshot  <= '0;
            for (int k = 0; k < NUM_CH; k++) gnt_cnt[k] <= 4'd0;
        end else begin
            if (state == ST_START) begin
                wt_shadow <= wt_stage;
                ivl_cnt   <= (ivl_len == '0) ? IVL_W'(1) : ivl_len;
                for (int k = 0; k < NUM_CH; k++) gnt_cnt[k] <= 4'd0;
            end else begin
                if (state == ST_RUN)
                    ivl_cnt <= ivl_cnt - IVL_W'(1);
                if ((state == ST_RUN) || (state == ST_DRAIN)) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (bus.gnt_vec[k] && cnt_event && (gnt_cnt[k] != 4'hF))
                            gnt_cnt[k] <= gnt_cnt[k] + 4'd1;
                    end
                end
            end
            if (close_ivl) begin
                for (int k = 0; k < NUM_CH; k++) snapshot[4*k +: 4] <= gnt_cnt[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable   <= 1'b0;
            wt_stage <= WT_RST;
            ivl_len  <= IVL_RST;
            to_len   <= TO_RST;
        end else if (bus.cfg_wr) begin
            case (bus.cfg_addr)
                ADDR_CTRL:     enable   <= bus.cfg_wdata[0];
                ADDR_WT_STAGE: wt_stage <= bus.cfg_wdata;
                ADDR_IVL_LEN:  ivl_len  <= bus.cfg_wdata;
                ADDR_TO_LEN:   to_len   <= bus.cfg_wdata[TO_W-1:0];
                default: ;
            endcase
        end
    end

    // A watchdog event in the same cycle as a clear request keeps the error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               timeout_err <= 1'b0;
        else if (err_set)                        timeout_err <= 1'b1;
        else if (ctrl_wr && bus.cfg_wdata[1])    timeout_err <= 1'b0;
    end

    always_comb begin
        bus.cfg_rdata = 16'h0000;
        case (bus.cfg_addr)
            ADDR_CTRL:     bus.cfg_rdata = {15'd0, enable};
            ADDR_WT_STAGE: bus.cfg_rdata = wt_stage;
            ADDR_IVL_LEN:  bus.cfg_rdata = ivl_len;
            ADDR_TO_LEN:   bus.cfg_rdata = {8'd0, to_len};
            ADDR_STATUS:   bus.cfg_rdata = {11'd0, state, err_ch, timeout_err};
            ADDR_GNT_SNAP: bus.cfg_rdata = snapshot;
            default:       bus.cfg_rdata = 16'h0000;
        endcase
    end

    wrr_tenure_watchdog u_watchdog (
        .clk            (clk),
        .reset          (reset),
        .active         (state != ST_IDLE),
        .to_len         (to_len),
        .gnt_vec        (bus.gnt_vec),
        .end_access_vec (bus.end_access_vec),
        .gnt_q          (gnt_q),
        .force_end_vec  (bus.force_end_vec),
        .err_set        (err_set),
        .err_ch         (err_ch)
    );

    assign bus.req_n_valid   = (state == ST_START);
    assign bus.interval_done = close_ivl;
    assign bus.timeout_err   = timeout_err;
    assign bus.req_vec_wt_0  = wt_active[3:0];
    assign bus.req_vec_wt_1  = wt_active[7:4];
    assign bus.req_vec_wt_2  = wt_active[11:8];
    assign bus.req_vec_wt_3  = wt_active[15:12];

endmodule

// File: tb/tb_wrr_interval_ctrl.sv
// Bench for wrr_interval_ctrl: directed scenarios with literal expectations
// followed by a randomized phase; a behavioural model compares all outputs
// on every falling clock edge.
module tb_wrr_interval_ctrl;
    import wrr_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    wrr_interval_ctrl_if bus ();

    wrr_interval_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 start, 2 run, 3 drain
    int          m_phase, m_left, m_cyc, m_ts, m_ivl, m_to;
    int          m_cnt [4];
    int          m_snap [4];
    logic        m_en, m_terr;
    logic [1:0]  m_errch;
    logic [15:0] m_wt, m_shadow, e_wt, e_rd, m_snapp;
    logic [3:0]  m_g, m_e, m_gq;
    logic        m_free, m_brk, m_act, m_fire;

    always @(negedge clk) begin
        if (reset) begin
            m_phase = 0; m_left = 0; m_cyc = 0; m_ts = 0;
            m_ivl = 256; m_to = 0; m_en = 1'b0; m_terr = 1'b0; m_errch = 2'd0;
            m_wt = 16'h1111; m_shadow = 16'h1111; m_gq = 4'd0;
            for (int k = 0; k < 4; k++) begin m_cnt[k] = 0; m_snap[k] = 0; end
        end else begin
            m_g    = bus.gnt_vec;
            m_e    = bus.end_access_vec;
            m_free = (m_g == 0) || ((m_e & m_g) != 0);
            m_brk  = (m_g == 0) || (m_g != m_gq) || ((m_e & m_g) != 0);
            m_act  = (m_phase != 0);
            m_fire = m_act && (m_to != 0) && !m_brk && ((m_cyc - m_ts) == m_to);
            e_wt   = (m_phase == 1) ? m_wt : m_shadow;
            for (int k = 0; k < 4; k++) m_snapp[4*k +: 4] = 4'(m_snap[k]);
            case (bus.cfg_addr)
                3'd0:    e_rd = {15'd0, m_en};
                3'd1:    e_rd = m_wt;
                3'd2:    e_rd = 16'(m_ivl);
                3'd3:    e_rd = 16'(m_to);
                3'd4:    e_rd = {11'd0, 2'(m_phase), m_errch, m_terr};
                3'd5:    e_rd = m_snapp;
                default: e_rd = 16'd0;
            endcase
            chk("req_n_valid",   16'(bus.req_n_valid),   16'(m_phase == 1));
            chk("interval_done", 16'(bus.interval_done), 16'(m_phase == 3 && m_free));
            chk("force_end_vec", 16'(bus.force_end_vec), 16'(m_fire ? m_g : 4'd0));
            chk("timeout_err",   16'(bus.timeout_err),   16'(m_terr));
            chk("req_vec_wt",    {bus.req_vec_wt_3, bus.req_vec_wt_2, bus.req_vec_wt_1, bus.req_vec_wt_0}, e_wt);
            chk("cfg_rdata",     bus.cfg_rdata,          e_rd);

            // advance to the state after the coming rising edge
            if (!m_act || m_to == 0 || m_brk || m_fire) m_ts = m_cyc;
            if (m_fire) begin
                m_terr = 1'b1;
                for (int k = 0; k < 4; k++) if (m_g[k]) m_errch = 2'(k);
            end else if (bus.cfg_wr && bus.cfg_addr == 3'd0 && bus.cfg_wdata[1]) begin
                m_terr = 1'b0;
            end
            case (m_phase)
                0: if (m_en) m_phase = 1;
                1: begin
                    m_left = (m_ivl == 0) ? 1 : m_ivl;
                    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
                    m_shadow = m_wt;
                    m_phase = 2;
                end
                2: begin
                    for (int k = 0; k < 4; k++)
                        if (m_g[k] && ((m_g != m_gq) || ((m_e & m_gq) != 0)) && m_cnt[k] < 15) m_cnt[k]++;
                    m_left--;
                    if (!m_en || m_left == 0) m_phase = 3;
                end
                default: begin
                    if (m_free) begin
                        for (int k = 0; k < 4; k++) m_snap[k] = m_cnt[k];
                        m_phase = m_en ? 1 : 0;
                    end
                    for (int k = 0; k < 4; k++)
                        if (m_g[k] && ((m_g != m_gq) || ((m_e & m_gq) != 0)) && m_cnt[k] < 15) m_cnt[k]++;
                end
            endcase
            if (bus.cfg_wr) begin
                case (bus.cfg_addr)
                    3'd0: m_en  = bus.cfg_wdata[0];
                    3'd1: m_wt  = bus.cfg_wdata;
                    3'd2: m_ivl = int'(bus.cfg_wdata);
                    3'd3: m_to  = int'(bus.cfg_wdata[7:0]);
                    default: ;
                endcase
            end
            m_gq = m_g;
            m_cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc_();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        cyc_();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic wait_start(input string name);
        for (int i = 0; i < 60 && bus.req_n_valid !== 1'b1; i++) begin
            cyc_(); #1;
        end
        chk(name, 16'(bus.req_n_valid), 16'd1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && bus.interval_done !== 1'b1; i++) begin
            cyc_(); #1;
        end
        chk(name, 16'(bus.interval_done), 16'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

    initial begin
        int hold;
        reset = 1'b1;
        bus.cfg_wr = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_wdata = 16'd0;
        bus.gnt_vec = 4'd0; bus.end_access_vec = 4'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset values
        bus.cfg_addr = ADDR_WT_STAGE; #1;
        chk("rst_wt_stage", bus.cfg_rdata, 16'h1111);
        chk("rst_wt_out", {bus.req_vec_wt_3, bus.req_vec_wt_2, bus.req_vec_wt_1, bus.req_vec_wt_0}, 16'h1111);
        chk("rst_rnv", 16'(bus.req_n_valid), 16'd0);
        bus.cfg_addr = ADDR_STATUS; #1;
        chk("rst_state", 16'(bus.cfg_rdata[4:3]), 16'd0);

        // first interval: 8-cycle RUN, idle bus
        cyc_();
        cfg_write(ADDR_WT_STAGE, 16'h4321);
        cfg_write(ADDR_IVL_LEN, 16'd8);
        cfg_write(ADDR_CTRL, 16'h0001);
        cyc_(); #1;
        chk("start_rnv", 16'(bus.req_n_valid), 16'd1);
        chk("start_wt", {bus.req_vec_wt_3, bus.req_vec_wt_2, bus.req_vec_wt_1, bus.req_vec_wt_0}, 16'h4321);
        repeat (8) cyc_();
        #1 chk("run_last_no_done", 16'(bus.interval_done), 16'd0);
        cyc_(); #1;
        chk("drain_done", 16'(bus.interval_done), 16'd1);
        cyc_(); #1;
        chk("restart_rnv", 16'(bus.req_n_valid), 16'd1);

        // staged weights applied only at the next START
        cyc_();
        cfg_write(ADDR_WT_STAGE, 16'h2222);
        #1 chk("wt_held", {bus.req_vec_wt_3, bus.req_vec_wt_0}, 8'h41);
        cyc_();
        wait_start("start_after_stage");
        chk("wt_applied", {bus.req_vec_wt_3, bus.req_vec_wt_2, bus.req_vec_wt_1, bus.req_vec_wt_0}, 16'h2222);

        // tenure watchdog
        cyc_();
        cfg_write(ADDR_TO_LEN, 16'd4);
        bus.gnt_vec = 4'b0010; #1;
        chk("wd_c0", 16'(bus.force_end_vec), 16'd0);
        for (int k = 1; k < 4; k++) begin
            cyc_(); #1 chk("wd_pre", 16'(bus.force_end_vec), 16'd0);
        end
        cyc_(); #1 chk("wd_force", 16'(bus.force_end_vec), 16'b0010);
        cyc_(); #1 chk("wd_one_cycle", 16'(bus.force_end_vec), 16'd0);
        chk("wd_err", 16'(bus.timeout_err), 16'd1);
        bus.cfg_addr = ADDR_STATUS; #1;
        chk("wd_err_ch", 16'(bus.cfg_rdata[2:0]), 16'b011);
        cyc_();
        bus.gnt_vec = 4'd0;
        cfg_write(ADDR_CTRL, 16'h0003);
        #1 chk("wd_err_clr", 16'(bus.timeout_err), 16'd0);

        // grant counting over one interval
        wait_start("start_cnt");
        cyc_(); bus.gnt_vec = 4'b0001;
        cyc_(); bus.gnt_vec = 4'b0010;
        cyc_(); bus.end_access_vec = 4'b0010;
        cyc_(); bus.gnt_vec = 4'b1000; bus.end_access_vec = 4'd0;
        cyc_(); bus.gnt_vec = 4'd0;
        wait_done("done_cnt");
        cyc_(); bus.cfg_addr = ADDR_GNT_SNAP; #1;
        chk("gnt_snap", bus.cfg_rdata, 16'h1021);

        // disable mid-RUN with a busy holder
        cfg_write(ADDR_TO_LEN, 16'd0);
        wait_start("start_dis");
        cyc_(); bus.gnt_vec = 4'b0100;
        cyc_(); cfg_write(ADDR_CTRL, 16'h0000);
        cyc_(); bus.cfg_addr = ADDR_STATUS; #1;
        chk("dis_drain", 16'(bus.cfg_rdata[4:3]), 16'd3);
        for (int k = 0; k < 3; k++) begin
            cyc_(); #1;
            chk("dis_hold", 16'({bus.cfg_rdata[4:3], bus.interval_done}), 16'b110);
        end
        cyc_(); bus.end_access_vec = 4'b0100; #1;
        chk("dis_done", 16'(bus.interval_done), 16'd1);
        cyc_(); bus.end_access_vec = 4'd0; bus.gnt_vec = 4'd0; #1;
        chk("dis_idle", 16'(bus.cfg_rdata[4:3]), 16'd0);

        // randomized phase
        cyc_();
        cfg_write(ADDR_CTRL, 16'h0001);
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            int r;
            if (hold == 0) begin
                r = $urandom_range(0, 4);
                bus.gnt_vec = (r == 4) ? 4'd0 : 4'(1 << r);
                hold = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 5) == 0)      bus.end_access_vec = bus.gnt_vec;
            else if ($urandom_range(0, 9) == 0) bus.end_access_vec = 4'($urandom);
            else                                bus.end_access_vec = 4'd0;
            bus.cfg_addr = 3'($urandom_range(0, 7));
            bus.cfg_wr   = ($urandom_range(0, 5) == 0);
            bus.cfg_wdata = 16'($urandom);
            if (bus.cfg_addr == ADDR_IVL_LEN) bus.cfg_wdata = 16'($urandom_range(0, 12));
            if (bus.cfg_addr == ADDR_TO_LEN)  bus.cfg_wdata = {8'($urandom), 8'($urandom_range(0, 6))};
            if (bus.cfg_addr == ADDR_CTRL)    bus.cfg_wdata[0] = ($urandom_range(0, 7) != 0);
            cyc_();
        end
        bus.cfg_wr = 1'b0; bus.gnt_vec = 4'd0; bus.end_access_vec = 4'd0;

        // asynchronous reset in the middle of START
        cfg_write(ADDR_CTRL, 16'h0001);
        wait_start("start_rst");
        #1 reset = 1'b1;
        #1 chk("rst_rnv_drop", 16'(bus.req_n_valid), 16'd0);
        chk("rst_force", 16'(bus.force_end_vec), 16'd0);
        cyc_(); cyc_();
        reset = 1'b0;
        bus.cfg_addr = ADDR_STATUS; #1;
        chk("rst2_status", bus.cfg_rdata, 16'd0);
        chk("rst2_wt", {bus.req_vec_wt_3, bus.req_vec_wt_2, bus.req_vec_wt_1, bus.req_vec_wt_0}, 16'h1111);
        repeat (4) cyc_();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
